// File: rtl/risc_pkg.sv
// Shared datapath constants for the token steering blocks.
// Token width, output select encodings and statistics counter width.
package risc_pkg;

   localparam int   DATA_W_TOKEN = 3;
   localparam logic SEL_OUT0     = 1'b0;
   localparam logic SEL_OUT1     = 1'b1;
   localparam int   STATS_W      = 16;

endpackage

// File: rtl/sync_fifo_sm.sv
// Single-clock FIFO with push/pop handshake, full/empty flags and an occupancy count.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo_sm #(
   parameter int DATA_W = 3,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       occ;
   logic              do_push;
   logic              do_pop;

   assign full    = (occ == FULL_CNT);
   assign empty   = (occ == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         // NOTE: the storage is cleared too, because head is always visible and must read 0 after reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/demux_1to2_3b_buf.sv
// Buffered 1-to-2 token demux: select steers each token into FIFO0 (ALU) or FIFO1 (load/store).
// Optional push/stall statistics are enabled with `define DEMUX_1TO2_STATS_EN.
module demux_1to2_3b_buf
   import risc_pkg::*;
#(
   parameter int DATA_W = DATA_W_TOKEN,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              select,
   output logic              out0_valid,
   input  logic              out0_ready,
   output logic [DATA_W-1:0] out0_data,
   output logic              out1_valid,
   input  logic              out1_ready,
   output logic [DATA_W-1:0] out1_data
`ifdef DEMUX_1TO2_STATS_EN
   ,
   output logic [STATS_W-1:0] cnt0,
   output logic [STATS_W-1:0] cnt1,
   output logic [STATS_W-1:0] stall_cnt
`endif
);

   logic full0, full1;
   logic empty0, empty1;
   logic push0, push1;

   // in_ready looks only at the selected FIFO; a pop in the same cycle does not free a slot early.
   always_comb begin
      in_ready = !full0;
      if (select == SEL_OUT1) begin
         in_ready = !full1;
      end
   end

   assign push0      = in_valid && in_ready && (select == SEL_OUT0);
   assign push1      = in_valid && in_ready && (select == SEL_OUT1);
   assign out0_valid = !empty0;
   assign out1_valid = !empty1;

   sync_fifo_sm #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
      .clk       (clk),
      .rst       (rst),
      .push      (push0),
      .push_data (in_data),
      .pop       (out0_valid && out0_ready),
      .full      (full0),
      .empty     (empty0),
      .head      (out0_data)
   );

   sync_fifo_sm #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
      .clk       (clk),
      .rst       (rst),
      .push      (push1),
      .push_data (in_data),
      .pop       (out1_valid && out1_ready),
      .full      (full1),
      .empty     (empty1),
      .head      (out1_data)
   );

`ifdef DEMUX_1TO2_STATS_EN
   // Counters wrap naturally at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0      <= '0;
         cnt1      <= '0;
         stall_cnt <= '0;
      end else begin
         if (push0) cnt0 <= cnt0 + 1'b1;
         if (push1) cnt1 <= cnt1 + 1'b1;
         if (in_valid && !in_ready) stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: doc/demux_1to2_3b_buf.md
Name: demux_1to2_3b_buf

Overview:
- Buffered 1-to-2 demultiplexer for 3-bit tokens; counterpart of the 2-to-1 3-bit selector in the datapath.
- Steers each token from one producer to one of two consumers, chosen by `select`.
- Valid/ready handshake on every side, with a per-output FIFO so one stalled consumer does not block traffic to the other.
- Sits between the decode stage and the two execution-side consumers: ALU path on out0, load/store path on out1.

Parameters:
- DATA_W, 3, token width in bits.
- DEPTH, 2, entries per output FIFO; must be a power of two, ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a token
- in_ready  output  1  selected FIFO can accept
- in_data  input  DATA_W  token
- select  input  1  0 → out0, 1 → out1; sampled with in_data
- out0_valid  output  1  FIFO0 non-empty
- out0_ready  input  1  consumer 0 accepts
- out0_data  output  DATA_W  FIFO0 head
- out1_valid  output  1  FIFO1 non-empty
- out1_ready  input  1  consumer 1 accepts
- out1_data  output  DATA_W  FIFO1 head

Behaviour:
- One clock domain. Reset is synchronous and active-high: `rst` is sampled on the `clk` rising edge.
- Reset values:
  - both FIFOs empty; pointers 0
  - out0_valid = out1_valid = 0
  - out0_data = out1_data = 0
  - in_ready reflects empty FIFOs, so it is 1 after reset.
- in_ready is combinational: select ? !full1 : !full0.
  - Depends on select and FIFO state only, never on in_valid.
- Push:
  - Occurs when in_valid && in_ready at the clock edge.
  - Writes in_data into FIFO[select]; the other FIFO is untouched.
- Pop:
  - Occurs when outN_valid && outN_ready.
  - Advances FIFO N read pointer.
- Latency:
  - Token pushed at edge k appears on outN_data/outN_valid after edge k (visible in cycle k+1).
  - No combinational in→out path.
- outN_data:
  - Always equals the entry at the FIFO N read pointer.
  - Undefined content is not allowed: shows the last written value or 0 after reset.
- Occupancy counter per FIFO, width clog2(DEPTH)+1:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged, both pointers advance.
- Full FIFO:
  - in_ready = 0 for that select, even if the consumer pops in the same cycle (no bypass or fall-through).
  - Producer must hold in_valid, in_data and select stable until accepted.
- Empty FIFO: outN_valid = 0; outN_ready is ignored.
- Pointers wrap modulo DEPTH.
- Ordering:
  - Per-output FIFO order is preserved.
  - No ordering guarantee across the two outputs.
- Producer changing select while in_valid is high and unaccepted is a protocol violation; the block takes no special action.
- Reset mid-operation: all buffered tokens are discarded; state is as at power-up on the next cycle.

Optional Feature:
- Macro: DEMUX_1TO2_STATS_EN.
- When defined, adds outputs:
  - cnt0 (16 bits): tokens pushed to FIFO0
  - cnt1 (16 bits): tokens pushed to FIFO1
  - stall_cnt (16 bits): cycles with in_valid && !in_ready
- Counter rules:
  - All counters increment on the same edge as the event and wrap at 0xFFFF → 0.
  - All counters are cleared by rst.
- When not defined: the ports do not exist and no counter logic is generated.

Decomposition:
- Shared package (risc_pkg):
  - DATA_W_TOKEN = 3
  - SEL_OUT0 = 1'b0, SEL_OUT1 = 1'b1
  - 16-bit stats counter width constant
- Sub-module sync_fifo_sm: single-clock FIFO with push/pop, full/empty and occupancy, parameterised by DATA_W and DEPTH.
  - Instantiated twice.
  - Top level holds only steering, in_ready and the optional stats.

Test Plan:
- Reset release: rst high 2 cycles → out0_valid = out1_valid = 0, out0_data = out1_data = 0, in_ready = 1.
- Steering: push 3'b101 with select = 0, then 3'b010 with select = 1, both consumers ready → out0 shows 101 and out1 shows 010, each one cycle after its push; per-output FIFO order holds.
- Full and back-pressure:
  - out0_ready = 0; push 3'b001, then 3'b011 with select = 0 → in_ready = 0 while select = 0, but in_ready = 1 with select = 1 and a push of 3'b111 reaches out1.
  - Release out0_ready → 001, then 011 emerge in order.
- Full with simultaneous pop: FIFO0 full, out0_ready = 1, select = 0, in_valid = 1 → no push that cycle (in_ready = 0); push accepted next cycle.
- Pointer wrap: stream 8 tokens 0..7 through out0 with always-ready consumer → output sequence 0..7, no loss or duplication.
- Reset mid-stream: FIFO1 holds 2 tokens; assert rst → out1_valid = 0 next cycle, later pushes start fresh. With DEMUX_1TO2_STATS_EN defined, cnt0, cnt1 and stall_cnt read 0 after reset.
